// File: rtl/sdram_request_queue_if.sv
// User-facing streams of the SDRAM request queue: request, write-beat and
// read-response channels, grouped so they can be passed as one port.
//
// Handshake (req and wr channels): a transfer happens on a rising clk edge
// where valid and ready are both high. While valid is high and ready is low
// the sender holds its payload stable. The rsp channel is push-only:
// rsp_valid marks a beat and there is no ready, so the receiver must always
// take it.
interface sdram_request_queue_if #(
    parameter int USER_ADDRESS_WIDTH = 24,
    parameter int DATA_WIDTH         = 16
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [USER_ADDRESS_WIDTH-1:0] req_address;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_last;

    modport master (
        output req_valid, req_write, req_address, wr_valid, wr_data,
        input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_address, wr_valid, wr_data,
        output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/sdram_request_queue.sv
// Request front-end for the SDRAM controller. Queues read/write requests,
// collects write beats, then drives the controller's level-held command,
// address and write data one operation at a time. Read beats are returned
// one cycle after data_read_valid on the push-only rsp stream.
// state_dbg exposes the FSM state for checkers.
module sdram_request_queue #(
    parameter int USER_ADDRESS_WIDTH = 24,
    parameter int DATA_WIDTH         = 16,
    parameter int BURST_LENGTH       = 1,
    parameter int WRITE_BURST        = 1,
    parameter int QUEUE_DEPTH        = 4,
    parameter int QUIET_CYCLES       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    sdram_request_queue_if.slave          usr,
    output logic                          busy,
    output logic [1:0]                    command,
    output logic [USER_ADDRESS_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0]         data_write,
    input  logic [DATA_WIDTH-1:0]         data_read,
    input  logic                          data_read_valid,
    input  logic                          data_write_done,
    output logic [2:0]                    state_dbg
);
    // Beats per write operation.
    localparam int WB      = (WRITE_BURST != 0) ? BURST_LENGTH : 1;
    localparam int BIDX_W  = $clog2(WB + 1);
    // Buffer covers every value beat_idx can encode so indexing is always in range.
    localparam int BUF_N   = 1 << BIDX_W;
    localparam int RCNT_W  = $clog2(BURST_LENGTH + 1);
    localparam int QCNT_W  = $clog2(QUIET_CYCLES + 1);
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int ENTRY_W = USER_ADDRESS_WIDTH + 1;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_DRAIN = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_WR    = 3'd3,
        S_RD    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ENTRY_W-1:0]            fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]              rd_ptr, wr_ptr;
    logic [CNT_W-1:0]              fifo_cnt;
    logic                          fifo_full, fifo_empty, push, pop;
    logic                          head_write;
    logic [USER_ADDRESS_WIDTH-1:0] head_address;

    logic [QCNT_W-1:0]     quiet_cnt;
    logic [BIDX_W-1:0]     beat_idx;
    logic [RCNT_W-1:0]     rd_cnt;
    logic [DATA_WIDTH-1:0] beat_buf [BUF_N];

    logic event_seen, quiet_done, load_last, wr_last, rd_last;

    assign fifo_full    = (fifo_cnt == CNT_W'(QUEUE_DEPTH));
    assign fifo_empty   = (fifo_cnt == '0);
    assign {head_write, head_address} = fifo_mem[rd_ptr];
    assign push         = usr.req_valid && !fifo_full;
    assign usr.req_ready = !fifo_full;
    assign usr.wr_ready  = (state_q == S_LOAD);

    // Any controller activity restarts the drain window.
    assign event_seen = data_read_valid || data_write_done;
    assign quiet_done = !event_seen && (quiet_cnt == QCNT_W'(QUIET_CYCLES - 1));
    assign load_last  = usr.wr_valid && (beat_idx == BIDX_W'(WB - 1));
    assign wr_last    = data_write_done && (beat_idx == BIDX_W'(WB - 1));
    assign rd_last    = data_read_valid && (rd_cnt == RCNT_W'(BURST_LENGTH - 1));

    assign data_write = beat_buf[beat_idx];
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign state_dbg  = state_q;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_DRAIN;
        else       state_q <= state_d;
    end

    // Next-state logic; the queue is popped only from IDLE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_DRAIN: if (quiet_done) state_d = S_IDLE;
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_write ? S_LOAD : S_RD;
                end
            end
            S_LOAD:  if (load_last) state_d = S_WR;
            S_WR:    if (wr_last)   state_d = S_IDLE;
            S_RD:    if (rd_last)   state_d = S_IDLE;
            default: state_d = S_DRAIN;
        endcase
    end

    // Count consecutive event-free cycles while draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                quiet_cnt <= '0;
        else if (state_q != S_DRAIN || event_seen) quiet_cnt <= '0;
        else if (!quiet_done)                      quiet_cnt <= quiet_cnt + 1'b1;
    end

    // Request FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Request FIFO storage; contents are only read once an entry is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {usr.req_write, usr.req_address};
    end

    // Controller-facing registers, beat tracking and the read response path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            command       <= CMD_IDLE;
            data_address  <= '0;
            beat_idx      <= '0;
            rd_cnt        <= '0;
            usr.rsp_valid <= 1'b0;
            usr.rsp_data  <= '0;
            usr.rsp_last  <= 1'b0;
            for (int i = 0; i < BUF_N; i++) beat_buf[i] <= '0;
        end else begin
            usr.rsp_valid <= (state_q == S_RD) && data_read_valid;
            usr.rsp_data  <= data_read;
            usr.rsp_last  <= (state_q == S_RD) && rd_last;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        data_address <= head_address;
                        beat_idx     <= '0;
                        rd_cnt       <= '0;
                        if (!head_write) command <= CMD_READ;
                    end
                end
                S_LOAD: begin
                    if (usr.wr_valid) begin
                        beat_buf[beat_idx] <= usr.wr_data;
                        if (load_last) begin
                            command  <= CMD_WRITE;
                            beat_idx <= '0;
                        end else begin
                            beat_idx <= beat_idx + 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (data_write_done) begin
                        if (wr_last) begin
                            command  <= CMD_IDLE;
                            beat_idx <= '0;
                        end else begin
                            beat_idx <= beat_idx + 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (data_read_valid) begin
                        if (rd_last) begin
                            command <= CMD_IDLE;
                            rd_cnt  <= '0;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
